// File: rtl/duck_pkg.sv
// Shared types for the Duck Hunt light-gun path: pattern-generator flash
// modes, gun controller states and the lit-sample counter width.
package duck_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        BLACK  = 2'd1,
        TARGET = 2'd2
    } flash_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        DARK  = 3'd2,
        LIT   = 3'd3,
        JUDGE = 3'd4
    } gun_state_t;

    localparam int LIT_CNT_W = 8;

    // Pattern the display must show while the controller sits in a state.
    function automatic flash_mode_t flash_of(input gun_state_t s);
        case (s)
            DARK:    return BLACK;
            LIT:     return TARGET;
            default: return NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Trigger conditioning: 2-flop synchronizer followed by a stable-count filter.
// The debounced level only follows the synced input after it has disagreed
// with the current level for DEBOUNCE_CYCLES consecutive cycles.
module trigger_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic trig_i,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q, level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer flops and filter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/gun_controller.sv
// Light-gun shot sequencer: on a debounced trigger press it drives one black
// frame and one target frame through flash_mode, samples the photodiode and
// pulses hit or miss. Optional macro GUN_DARK_CHECK_EN makes any light seen
// during the black frame force a miss (rejects aiming at a lamp).
module gun_controller
    import duck_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HIT_THRESHOLD   = 16,
    parameter int SHOTS           = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       valid,
    input  logic       trigger,
    input  logic       detect,
    input  logic       round_start,
    output logic [1:0] flash_mode,
    output logic       hit,
    output logic       miss,
    output logic [1:0] shots_left,
    output logic       busy
);

    localparam logic [LIT_CNT_W-1:0] HIT_THR    = LIT_CNT_W'(HIT_THRESHOLD);
    localparam logic [1:0]           SHOTS_INIT = 2'(SHOTS);

    gun_state_t           state_q, state_d;
    logic [LIT_CNT_W-1:0] lit_count_q, lit_count_d;
    logic [1:0]           shots_q, shots_d;
    logic                 hit_q, hit_d, miss_q, miss_d;
    flash_mode_t          flash_q;
    logic                 busy_q;
    logic                 det_s1_q, det_s2_q;
    logic                 trig_level_s, trig_prev_q, press_s, hit_ok_s;
`ifdef GUN_DARK_CHECK_EN
    logic                 dark_seen_q, dark_seen_d;
`endif

    trigger_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig (
        .clk     (clk),
        .reset   (reset),
        .trig_i  (trigger),
        .level_o (trig_level_s)
    );

    // Only the rising edge of the debounced level starts a shot.
    assign press_s = trig_level_s & ~trig_prev_q;

`ifdef GUN_DARK_CHECK_EN
    assign hit_ok_s = (lit_count_q >= HIT_THR) && !dark_seen_q;
`else
    assign hit_ok_s = (lit_count_q >= HIT_THR);
`endif

    // Next-state, sample counters, scoring and shot bookkeeping.
    always_comb begin
        state_d     = state_q;
        lit_count_d = lit_count_q;
        shots_d     = shots_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
`ifdef GUN_DARK_CHECK_EN
        dark_seen_d = dark_seen_q;
`endif
        if (round_start) begin
            state_d     = IDLE;
            shots_d     = SHOTS_INIT;
            lit_count_d = '0;
`ifdef GUN_DARK_CHECK_EN
            dark_seen_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_s && (shots_q != 2'd0)) begin
                        state_d = ARM;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARM: begin
                    if (frame_start) begin
                        state_d     = DARK;
                        lit_count_d = '0;
`ifdef GUN_DARK_CHECK_EN
                        dark_seen_d = 1'b0;
`endif
                    end else begin
                        state_d = ARM;
                    end
                end
                DARK: begin
`ifdef GUN_DARK_CHECK_EN
                    if (valid && det_s2_q) begin
                        dark_seen_d = 1'b1;
                    end else begin
                        dark_seen_d = dark_seen_q;
                    end
`endif
                    if (frame_start) begin
                        state_d = LIT;
                    end else begin
                        state_d = DARK;
                    end
                end
                LIT: begin
                    if (valid && det_s2_q && (lit_count_q != {LIT_CNT_W{1'b1}})) begin
                        lit_count_d = lit_count_q + LIT_CNT_W'(1);
                    end else begin
                        lit_count_d = lit_count_q;
                    end
                    if (frame_start) begin
                        state_d = JUDGE;
                        hit_d   = hit_ok_s;
                        miss_d  = !hit_ok_s;
                        if (shots_q != 2'd0) begin
                            shots_d = shots_q - 2'd1;
                        end else begin
                            shots_d = 2'd0;
                        end
                    end else begin
                        state_d = LIT;
                    end
                end
                JUDGE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lit_count_q <= '0;
            shots_q     <= SHOTS_INIT;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            flash_q     <= NORMAL;
            busy_q      <= 1'b0;
            det_s1_q    <= 1'b0;
            det_s2_q    <= 1'b0;
            trig_prev_q <= 1'b0;
`ifdef GUN_DARK_CHECK_EN
            dark_seen_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lit_count_q <= lit_count_d;
            shots_q     <= shots_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            flash_q     <= flash_of(state_d);
            busy_q      <= (state_d != IDLE);
            det_s1_q    <= detect;
            det_s2_q    <= det_s1_q;
            trig_prev_q <= trig_level_s;
`ifdef GUN_DARK_CHECK_EN
            dark_seen_q <= dark_seen_d;
`endif
        end
    end

    assign flash_mode = flash_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign shots_left = shots_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gun_controller.sv
// Bench for gun_controller: 100-cycle frames (40 blank, then 60 visible),
// table of shot scenarios plus hand-written trigger/round_start sequences.
// Expected hit/miss/shots_left are queued per shot and popped on each pulse.
module tb_gun_controller;

    logic       clk = 1'b0;
    logic       reset, frame_start, valid, trigger, detect, round_start;
    logic [1:0] flash_mode, shots_left;
    logic       hit, miss, busy;

    gun_controller #(
        .DEBOUNCE_CYCLES(4),
        .HIT_THRESHOLD  (16),
        .SHOTS          (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .valid       (valid),
        .trigger     (trigger),
        .detect      (detect),
        .round_start (round_start),
        .flash_mode  (flash_mode),
        .hit         (hit),
        .miss        (miss),
        .shots_left  (shots_left),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dark_n;
        int lit_n;
        bit blank;
        bit hold;
        bit lat;
        bit exp_hit;
    } vec_t;

    typedef struct {
        bit h;
        int s;
    } exp_t;

    vec_t tbl[5];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   pos = 0;
    int   det_lo = 0;
    int   det_hi = 0;
    int   pulses = 0;
    int   exp_shots = 3;
    bit   busy_seen = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive frame inputs at negedge, sample outputs 1 after posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        frame_start = (pos == 0);
        valid       = (pos >= 40);
        detect      = (pos >= det_lo) && (pos < det_hi);
        @(posedge clk);
        #1;
        pos = (pos == 99) ? 0 : pos + 1;
        if (busy) busy_seen = 1'b1;
        if (hit || miss) begin
            pulses++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got hit=%0d miss=%0d expected none", hit, miss);
            end else begin
                e = sb.pop_front();
                chk("hit", int'(hit), int'(e.h));
                chk("miss", int'(miss), int'(!e.h));
                chk("shots_at_judge", int'(shots_left), e.s);
            end
        end
    endtask

    task automatic do_shot(input vec_t v);
        int k;
        int np;
        exp_t e;
        trigger = 1'b1;
        if (v.lat) begin
            repeat (6) step();
            chk("arm_lat_early", int'(busy), 0);
            step();
            chk("arm_lat", int'(busy), 1);
        end else begin
            k = 0;
            while (!busy && k < 40) begin
                step();
                k++;
            end
            chk("arm_seen", int'(busy), 1);
        end
        if (!v.hold) trigger = 1'b0;
        exp_shots = exp_shots - 1;
        e.h = v.exp_hit;
        e.s = exp_shots;
        sb.push_back(e);
        k = 0;
        while (pos != 0 && k < 200) begin
            step();
            k++;
        end
        det_lo = 40;
        det_hi = 40 + v.dark_n;
        step();
        chk("flash_dark", int'(flash_mode), 1);
        chk("busy_dark", int'(busy), 1);
        repeat (99) step();
        chk("flash_dark_end", int'(flash_mode), 1);
        if (v.blank) begin
            det_lo = 0;
            det_hi = 38;
        end else begin
            det_lo = 40;
            det_hi = 40 + v.lit_n;
        end
        step();
        chk("flash_lit", int'(flash_mode), 2);
        repeat (99) step();
        chk("flash_lit_end", int'(flash_mode), 2);
        det_lo = 0;
        det_hi = 0;
        np = pulses;
        step();
        chk("flash_judge", int'(flash_mode), 0);
        chk("busy_judge", int'(busy), 1);
        chk("pulse_seen", pulses - np, 1);
        step();
        chk("busy_idle", int'(busy), 0);
        chk("no_pulse_after", int'(hit || miss), 0);
    endtask

    initial begin
        int k;
        tbl[0] = '{dark_n: 0,  lit_n: 20, blank: 1'b0, hold: 1'b0, lat: 1'b1, exp_hit: 1'b1};
        tbl[1] = '{dark_n: 0,  lit_n: 15, blank: 1'b0, hold: 1'b1, lat: 1'b0, exp_hit: 1'b0};
        tbl[2] = '{dark_n: 0,  lit_n: 0,  blank: 1'b1, hold: 1'b0, lat: 1'b0, exp_hit: 1'b0};
`ifdef GUN_DARK_CHECK_EN
        tbl[3] = '{dark_n: 10, lit_n: 20, blank: 1'b0, hold: 1'b0, lat: 1'b0, exp_hit: 1'b0};
`else
        tbl[3] = '{dark_n: 10, lit_n: 20, blank: 1'b0, hold: 1'b0, lat: 1'b0, exp_hit: 1'b1};
`endif
        tbl[4] = '{dark_n: 0,  lit_n: 16, blank: 1'b0, hold: 1'b0, lat: 1'b0, exp_hit: 1'b1};

        reset = 1'b1;
        trigger = 1'b0;
        round_start = 1'b0;
        frame_start = 1'b0;
        valid = 1'b0;
        detect = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_shots", int'(shots_left), 3);
        chk("rst_flash", int'(flash_mode), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_miss", int'(miss), 0);

        // Bouncing trigger: 2-cycle pulses never satisfy the 4-cycle filter.
        busy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            trigger = 1'b1;
            repeat (2) step();
            trigger = 1'b0;
            repeat (2) step();
        end
        repeat (20) step();
        chk("bounce_no_shot", int'(busy_seen), 0);

        for (int i = 0; i < 3; i++) begin
            do_shot(tbl[i]);
            if (tbl[i].hold) begin
                busy_seen = 1'b0;
                repeat (50) step();
                chk("held_no_second_shot", int'(busy_seen), 0);
                trigger = 1'b0;
                repeat (20) step();
            end
        end
        chk("shots_empty", int'(shots_left), 0);

        // Fourth press with no shots left is ignored.
        busy_seen = 1'b0;
        trigger = 1'b1;
        repeat (30) step();
        chk("empty_press_ignored", int'(busy_seen), 0);
        chk("empty_shots", int'(shots_left), 0);
        trigger = 1'b0;
        repeat (20) step();

        round_start = 1'b1;
        step();
        round_start = 1'b0;
        exp_shots = 3;
        chk("reload_shots", int'(shots_left), 3);

        for (int i = 3; i < 5; i++) do_shot(tbl[i]);
        chk("shots_after_5", int'(shots_left), 1);

        // round_start in the middle of the target frame aborts without a pulse.
        trigger = 1'b1;
        k = 0;
        while (!busy && k < 40) begin
            step();
            k++;
        end
        chk("abort_arm", int'(busy), 1);
        trigger = 1'b0;
        k = 0;
        while (pos != 0 && k < 200) begin
            step();
            k++;
        end
        repeat (100) step();
        det_lo = 40;
        det_hi = 70;
        step();
        chk("abort_in_lit", int'(flash_mode), 2);
        repeat (49) step();
        k = pulses;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        det_lo = 0;
        det_hi = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_flash", int'(flash_mode), 0);
        chk("abort_shots", int'(shots_left), 3);
        repeat (250) step();
        chk("abort_no_pulse", pulses - k, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gun_controller.md
# gun_controller

Sequences each light-gun shot for the Duck Hunt display. On a debounced trigger press it takes over two whole video frames: one all-black frame, then one frame with only the white target drawn. It samples the photodiode during each frame and reports hit or miss. It sits between the trigger/detect pins and the pattern generator, which obeys `flash_mode`. It runs on the VGA pixel clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles before the trigger level is accepted (~10 ms).
- `HIT_THRESHOLD`, default 16: minimum detect-high visible cycles in the target frame to score a hit.
- `SHOTS`, default 3: shots per round, range 1–3.

Ports:
- `clk`, in, 1: pixel clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high.
- `frame_start`, in, 1: one-cycle pulse on the first cycle of vertical blanking, from the VGA timing block.
- `valid`, in, 1: current pixel is in the visible area.
- `trigger`, in, 1: raw asynchronous gun trigger, high = pressed.
- `detect`, in, 1: raw asynchronous photodiode output, high = light.
- `round_start`, in, 1: one-cycle pulse that reloads shots and aborts any shot in progress.
- `flash_mode`, out, 2: 0 = NORMAL, 1 = BLACK (whole screen black), 2 = TARGET (black except target box white).
- `hit`, out, 1: one-cycle pulse.
- `miss`, out, 1: one-cycle pulse.
- `shots_left`, out, 2: shots remaining.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- `trigger` and `detect` each pass through a 2-flop synchronizer.
- Debounced trigger: the output takes the new level only after the synced input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- A shot starts on the debounced rising edge only.
- State machine:
  - IDLE → ARM: debounced press and `shots_left` != 0. A press with `shots_left` == 0 is ignored.
  - ARM → DARK: on `frame_start`. Clears `lit_count` and `dark_seen`.
  - DARK → LIT: on `frame_start`. During DARK, `valid && detect_sync` sets `dark_seen`.
  - LIT → JUDGE: on `frame_start`. During LIT, `valid && detect_sync` increments `lit_count` (8-bit, saturates at 255).
  - JUDGE → IDLE: always, after one cycle.
- JUDGE scoring:
  - hit = (`lit_count` >= `HIT_THRESHOLD`) and the dark check passes (see Configuration).
  - Pulse exactly one of `hit`/`miss`.
  - Decrement `shots_left`, floor 0.
- `flash_mode` decodes from state: BLACK in DARK, TARGET in LIT, NORMAL otherwise.
- Trigger activity while `busy` is ignored and not queued. A new shot needs release and then a new press.
- `round_start` in any state:
  - `shots_left` ← `SHOTS`, state ← IDLE, counters cleared.
  - No `hit`/`miss` pulse is emitted.
  - `round_start` has priority over a coincident `frame_start` or trigger edge.
- Reset values: state IDLE, `flash_mode` 0, `hit` 0, `miss` 0, `busy` 0, `shots_left` = `SHOTS`, debounced trigger 0, synchronizers 0.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- `frame_start` seen in cycle N → new state and `flash_mode` valid in cycle N+1, which is within blanking, before any visible pixel.
- Detect latency: 2 cycles (synchronizer). Samples taken in the last 2 cycles of a frame's blanking are harmless because `valid` is low there.
- Press → ARM: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- Shot duration: from the first `frame_start` after ARM, exactly two frames, then JUDGE. `hit`/`miss` pulse in the cycle after the third `frame_start`.
- `busy` is high from ARM entry through the JUDGE cycle, inclusive.

## Configuration
- `GUN_DARK_CHECK_EN` defined: `dark_seen` forces a miss regardless of `lit_count`. This rejects aiming at a lamp.
- Not defined: the DARK frame is still shown, but detect is ignored during DARK. `dark_seen` logic is omitted and hit depends only on `lit_count`.

## Structure
- Package `duck_pkg`:
  - `flash_mode_t` enum (NORMAL = 0, BLACK = 1, TARGET = 2).
  - `gun_state_t` enum (IDLE, ARM, DARK, LIT, JUDGE).
  - `LIT_CNT_W` = 8.
- Sub-module `trigger_debounce`: synchronizer plus stable-count filter, parameterized by `DEBOUNCE_CYCLES`, outputs the debounced level. `detect` uses a bare 2-flop synchronizer inline.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HIT_THRESHOLD`=16, `SHOTS`=3, with frames shortened to 100 cycles of which 60 have `valid` high.
- Reset → `shots_left`=3, `flash_mode`=0, `busy`=0, no pulses. Press trigger → ARM after 7 cycles. `flash_mode` goes 1, then 2, each for one frame, then 0.
- Detect high for 20 valid cycles in LIT, low in DARK → single `hit` pulse the cycle after the 3rd `frame_start`; `shots_left`=2.
- Detect high for 15 valid cycles in LIT → `miss`. Detect high only while `valid`=0 → `miss`.
- Detect high in both DARK and LIT → `miss` with `GUN_DARK_CHECK_EN` defined, `hit` without it.
- Trigger bounce: pulses of 2 cycles → no shot. Hold trigger through a shot, then press again without releasing → no second shot.
- Three shots, then a fourth press → ignored, `shots_left`=0. `round_start` asserted mid-LIT → state IDLE, `shots_left`=3, no pulse, `flash_mode`=0 next cycle.
